// File: rtl/conv_pe_sequencer_pkg.sv
// Shared definitions for the conv PE sequencer: FSM state encoding and
// default sizing for the 16-PE conv datapath.
package conv_pe_sequencer_pkg;

    localparam int NUM_PE_DEF        = 16;
    localparam int START_DELAY_DEF   = 2;
    localparam int PIX_W_DEF         = 16;
    localparam int ACC_W_DEF         = 8;
    localparam int DRAIN_TIMEOUT_DEF = 1024;

    // Width of the shared cycle counter; must cover ACC_W values and DRAIN_TIMEOUT
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_PE_RST,
        S_ACCUM,
        S_FINISH,
        S_DRAIN,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/conv_seq_cycle_cnt.sv
// Loadable down-counter with zero flag. One instance times the WARMUP,
// ACCUM and DRAIN phases of the sequencer; a load of N gives N+1 cycles
// until zero is seen (the load cycle included).
module conv_seq_cycle_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over decrement; the counter parks at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/conv_pe_sequencer.sv
// Cycle-accurate sequencer for the 16-PE conv datapath. After a start it
// enables the datapath, issues one pe_reset / pe_finish window per OFM
// pixel, then waits for the matching all-PE valid strobes (bounded by a
// drain timeout) before pulsing done. All outputs are registered and are
// decoded from the next state, so outputs and state change on the same edge.
module conv_pe_sequencer
    import conv_pe_sequencer_pkg::*;
#(
    parameter int NUM_PE        = NUM_PE_DEF,
    parameter int START_DELAY   = START_DELAY_DEF,
    parameter int PIX_W         = PIX_W_DEF,
    parameter int ACC_W         = ACC_W_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  cfg_num_pixels,
    input  logic [ACC_W-1:0]  cfg_acc_cycles,
    input  logic [NUM_PE-1:0] valid,
    output logic              cal_start,
    output logic [NUM_PE-1:0] pe_reset,
    output logic [NUM_PE-1:0] pe_finish,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [PIX_W-1:0]  pix_issued,
    output logic [PIX_W-1:0]  pix_received
);

    seq_state_e       state_q, state_d;
    logic [PIX_W-1:0] num_q;
    logic [ACC_W-1:0] acc_q;
    logic             accept;
    logic             drain_tmo;
    logic             all_valid;
    logic [PIX_W-1:0] rcv_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // acc=0 is treated as a single accumulate cycle
    function automatic logic [CNT_W-1:0] acc_load(input logic [ACC_W-1:0] a);
        return (a == '0) ? '0 : CNT_W'(a) - 1'b1;
    endfunction

    assign accept    = (state_q == S_IDLE) && start && !abort;
    assign all_valid = busy && (&valid);
    // Received count including this cycle's strobe, so DRAIN can exit on the
    // same edge the last strobe is counted
    assign rcv_d     = all_valid ? sat_inc(pix_received) : pix_received;

    conv_seq_cycle_cnt #(
        .CNT_W(CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_val),
        .zero    (cnt_zero)
    );

    // Next-state logic and phase counter loading
    always_comb begin
        state_d   = state_q;
        drain_tmo = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = (cfg_num_pixels == '0) ? S_DONE : S_WARMUP;
            S_WARMUP: if (cnt_zero) state_d = S_PE_RST;
            S_PE_RST: state_d = S_ACCUM;
            S_ACCUM:  if (cnt_zero) state_d = S_FINISH;
            S_FINISH: state_d = (pix_issued == num_q) ? S_DRAIN : S_PE_RST;
            S_DRAIN: begin
                if (rcv_d == num_q) begin
                    state_d = S_DONE;
                end else if (cnt_zero) begin
                    state_d   = S_DONE;
                    drain_tmo = 1'b1;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && state_q != S_DONE) begin
            state_d   = S_IDLE;
            drain_tmo = 1'b0;
        end else if (abort) begin
            state_d = S_IDLE;
        end

        cnt_load = (state_d != state_q);
        case (state_d)
            S_WARMUP: cnt_val = CNT_W'(START_DELAY - 1);
            S_ACCUM:  cnt_val = acc_load(acc_q);
            S_DRAIN:  cnt_val = CNT_W'(DRAIN_TIMEOUT - 1);
            default:  cnt_val = '0;
        endcase
    end

    // State register and registered control outputs decoded from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cal_start <= 1'b0;
            pe_reset  <= '0;
            pe_finish <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cal_start <= (state_d inside {S_WARMUP, S_PE_RST, S_ACCUM, S_FINISH, S_DRAIN});
            pe_reset  <= {NUM_PE{state_d == S_PE_RST}};
            pe_finish <= {NUM_PE{state_d == S_FINISH}};
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

    // Per-run pixel counters and sticky drain timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_issued   <= '0;
            pix_received <= '0;
            timeout_err  <= 1'b0;
        end else if (accept) begin
            pix_issued   <= '0;
            pix_received <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (state_d == S_FINISH) pix_issued <= sat_inc(pix_issued);
            pix_received <= rcv_d;
            if (drain_tmo) timeout_err <= 1'b1;
        end
    end

    // Run configuration captured on an accepted start
    always_ff @(posedge clk) begin
        if (accept) begin
            num_q <= cfg_num_pixels;
            acc_q <= cfg_acc_cycles;
        end
    end

endmodule
